// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and load/store ports onto one single-port, fixed-latency
// memory. Round-robin on ties, one outstanding transaction, registered outputs.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    // instruction-fetch port (read-only)
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    // load/store data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    // memory side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = 4;

    // Latency must fit the wait counter and be at least one cycle.
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT out of range 1..15");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             last_data;   // 1: previous grant went to the data port
    logic             owner;       // 1: in-flight transaction belongs to the data port
    logic             sel_data;    // arbitration winner, 1 = data port
    logic             issue;       // a new transaction is granted this cycle
    logic             capture;     // memory read data is valid this cycle
    logic             respond;     // completion pulse is due next cycle

    // Round-robin choice: a lone request wins, a tie goes to the port not granted last.
    always_comb begin
        sel_data = 1'b0;
        if (f_req && d_req) begin
            sel_data = ~last_data;
        end else begin
            sel_data = d_req;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        next_state = state;
        count_nxt  = count;
        issue      = 1'b0;
        capture    = 1'b0;
        respond    = 1'b0;
        case (state)
            IDLE, RESP: begin
                if (f_req || d_req) begin
                    next_state = ISSUE;
                    issue      = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            ISSUE: begin
                if (mem_we) begin
                    next_state = RESP;
                    respond    = 1'b1;
                end else begin
                    next_state = WAIT;
                    count_nxt  = CNT_W'(MEM_LAT - 1);
                end
            end
            WAIT: begin
                if (count == '0) begin
                    next_state = RESP;
                    capture    = 1'b1;
                    respond    = 1'b1;
                end else begin
                    count_nxt = count - CNT_W'(1);
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Memory latency counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

    // Latch the winner's request onto the memory bus; held until the next grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_data <= 1'b1;
            owner     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (issue) begin
            last_data <= sel_data;
            owner     <= sel_data;
            if (sel_data) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else begin
                mem_we    <= 1'b0;
                mem_addr  <= f_addr;
                mem_wdata <= '0;
            end
        end
    end

    // One-cycle strobes: grant and memory enable in ISSUE, completion in RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            mem_en   <= 1'b0;
            f_rvalid <= 1'b0;
            d_done   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            f_gnt    <= issue & ~sel_data;
            d_gnt    <= issue & sel_data;
            mem_en   <= issue;
            f_rvalid <= respond & ~owner;
            d_done   <= respond & owner;
            busy     <= (next_state != IDLE);
        end
    end

    // Read data capture into the owning port's register; writes leave both untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_rdata <= '0;
            d_rdata <= '0;
        end else if (capture) begin
            if (owner) begin
                d_rdata <= mem_rdata;
            end else begin
                f_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 instance plus a MEM_LAT=1 instance.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    // MEM_LAT = 2 instance
    logic       f_req = 1'b0;
    logic [7:0] f_addr = '0;
    logic       d_req = 1'b0;
    logic       d_we = 1'b0;
    logic [7:0] d_addr = '0;
    logic [7:0] d_wdata = '0;
    logic       f_gnt, f_rvalid, d_gnt, d_done, mem_en, mem_we, busy;
    logic [7:0] f_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    // MEM_LAT = 1 instance
    logic       f1_req = 1'b0;
    logic [7:0] f1_addr = '0;
    logic       d1_req = 1'b0;
    logic       d1_we = 1'b0;
    logic [7:0] d1_addr = '0;
    logic [7:0] d1_wdata = '0;
    logic       f1_gnt, f1_rvalid, d1_gnt, d1_done, mem1_en, mem1_we, busy1;
    logic [7:0] f1_rdata, d1_rdata, mem1_addr, mem1_wdata, mem1_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(2)) u_dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .f_req(f1_req), .f_addr(f1_addr), .f_gnt(f1_gnt), .f_rvalid(f1_rvalid), .f_rdata(f1_rdata),
        .d_req(d1_req), .d_we(d1_we), .d_addr(d1_addr), .d_wdata(d1_wdata),
        .d_gnt(d1_gnt), .d_done(d1_done), .d_rdata(d1_rdata),
        .mem_en(mem1_en), .mem_we(mem1_we), .mem_addr(mem1_addr), .mem_wdata(mem1_wdata),
        .mem_rdata(mem1_rdata), .busy(busy1)
    );

    always #5 clk = ~clk;

    // Fixed memory contents; unlisted addresses read 0.
    function automatic logic [7:0] memval(input logic [7:0] a);
        case (a)
            8'h10:   memval = 8'hA5;
            8'h03:   memval = 8'h7E;
            8'h50:   memval = 8'h3C;
            8'h30:   memval = 8'hC3;
            8'h40:   memval = 8'h96;
            default: memval = 8'h00;
        endcase
    endfunction

    // Memory models: read data valid exactly MEM_LAT cycles after mem_en, 0xEE otherwise.
    logic       p1 = 1'b0, p2 = 1'b0, q1 = 1'b0;
    logic [7:0] a1 = '0, a2 = '0, b1 = '0;
    logic [7:0] wr_addr = '0, wr_data = '0;

    always @(posedge clk) begin
        p1 <= mem_en && !mem_we;
        a1 <= mem_addr;
        p2 <= p1;
        a2 <= a1;
        q1 <= mem1_en && !mem1_we;
        b1 <= mem1_addr;
        if (mem_en && mem_we) begin
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
    end

    assign mem_rdata  = p2 ? memval(a2) : 8'hEE;
    assign mem1_rdata = q1 ? memval(b1) : 8'hEE;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        checks++;
        if ({f_gnt, f_rvalid, d_gnt, d_done, mem_en, mem_we, busy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0", {f_gnt, f_rvalid, d_gnt, d_done, mem_en, mem_we, busy});
        end
        checks++;
        if ({f_rdata, d_rdata, mem_addr, mem_wdata} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", {f_rdata, d_rdata, mem_addr, mem_wdata});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_fetch_read();
        f_req = 1'b1; f_addr = 8'h10;
        step(); // cycle 1
        checks++;
        if ({f_gnt, d_gnt, mem_en, mem_we, mem_addr} !== {4'b1010, 8'h10}) begin
            errors++;
            $display("FAIL fetch_issue got %b_%h want 1010_10", {f_gnt, d_gnt, mem_en, mem_we}, mem_addr);
        end
        f_req = 1'b0;
        step(); // cycle 2
        checks++;
        if ({f_gnt, mem_en, f_rvalid} !== 3'b000) begin
            errors++;
            $display("FAIL fetch_wait2 got %b want 000", {f_gnt, mem_en, f_rvalid});
        end
        step(); // cycle 3
        checks++;
        if (f_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_early_rvalid got %b want 0", f_rvalid);
        end
        step(); // cycle 4
        checks++;
        if ({f_rvalid, d_done, busy, f_rdata} !== {3'b101, 8'hA5}) begin
            errors++;
            $display("FAIL fetch_resp got %b_%h want 101_a5", {f_rvalid, d_done, busy}, f_rdata);
        end
        step(); // cycle 5
        checks++;
        if ({f_rvalid, busy, f_rdata} !== {2'b00, 8'hA5}) begin
            errors++;
            $display("FAIL fetch_idle got %b_%h want 00_a5", {f_rvalid, busy}, f_rdata);
        end
    endtask

    task automatic test_data_write();
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h22; d_wdata = 8'h5C;
        step(); // cycle 1
        checks++;
        if ({d_gnt, f_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b1011, 8'h22, 8'h5C}) begin
            errors++;
            $display("FAIL write_issue got %b_%h_%h want 1011_22_5c",
                     {d_gnt, f_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
        end
        d_req = 1'b0; d_we = 1'b0;
        step(); // cycle 2
        checks++;
        if ({d_done, f_rvalid, mem_en, d_rdata} !== {3'b100, 8'h00}) begin
            errors++;
            $display("FAIL write_done got %b_%h want 100_00", {d_done, f_rvalid, mem_en}, d_rdata);
        end
        checks++;
        if ({wr_addr, wr_data} !== 16'h225C) begin
            errors++;
            $display("FAIL write_mem got %h want 225c", {wr_addr, wr_data});
        end
        step(); // cycle 3
        checks++;
        if ({busy, d_done, mem_addr, mem_we, d_rdata} !== {2'b00, 8'h22, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL write_after got %b_%h_%b_%h want 00_22_1_00", {busy, d_done}, mem_addr, mem_we, d_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int gcyc [4];
        logic gdat [4];
        bit overlap;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        f_req = 1'b1; f_addr = 8'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30;
        n = 0;
        overlap = 1'b0;
        for (int cyc = 1; cyc <= 40 && n < 4; cyc++) begin
            step();
            if ((f_gnt && d_gnt) || (f_rvalid && d_done)) overlap = 1'b1;
            if (f_gnt || d_gnt) begin
                gcyc[n] = cyc;
                gdat[n] = d_gnt;
                n++;
            end
            if (n == 4) begin
                f_req = 1'b0;
                d_req = 1'b0;
            end
        end
        f_req = 1'b0;
        d_req = 1'b0;
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL rr_grant_count got %0d want 4", n);
        end else begin
            checks++;
            if ({gdat[0], gdat[1], gdat[2], gdat[3]} !== 4'b0101) begin
                errors++;
                $display("FAIL rr_order got %b want 0101 (0=F 1=D)", {gdat[0], gdat[1], gdat[2], gdat[3]});
            end
            checks++;
            if (gcyc[0] != 1 || gcyc[1] != 5 || gcyc[2] != 9 || gcyc[3] != 13) begin
                errors++;
                $display("FAIL rr_timing got %0d %0d %0d %0d want 1 5 9 13", gcyc[0], gcyc[1], gcyc[2], gcyc[3]);
            end
        end
        for (int i = 0; i < 20 && busy; i++) begin
            step();
            if ((f_gnt && d_gnt) || (f_rvalid && d_done)) overlap = 1'b1;
        end
        checks++;
        if (overlap) begin
            errors++;
            $display("FAIL rr_exclusive got overlap 1 want 0");
        end
        checks++;
        if ({busy, f_rdata, d_rdata} !== {1'b0, 8'h96, 8'hC3}) begin
            errors++;
            $display("FAIL rr_final got %b_%h_%h want 0_96_c3", busy, f_rdata, d_rdata);
        end
    endtask

    task automatic test_lat1_read();
        d1_req = 1'b1; d1_we = 1'b0; d1_addr = 8'h03;
        step(); // cycle 1
        checks++;
        if ({d1_gnt, f1_gnt, mem1_en, mem1_we, mem1_addr} !== {4'b1010, 8'h03}) begin
            errors++;
            $display("FAIL lat1_issue got %b_%h want 1010_03", {d1_gnt, f1_gnt, mem1_en, mem1_we}, mem1_addr);
        end
        d1_req = 1'b0;
        step(); // cycle 2
        checks++;
        if (d1_done !== 1'b0) begin
            errors++;
            $display("FAIL lat1_early_done got %b want 0", d1_done);
        end
        step(); // cycle 3
        checks++;
        if ({d1_done, f1_rvalid, d1_rdata, f1_rdata, mem1_wdata} !== {2'b10, 8'h7E, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL lat1_done got %b_%h_%h_%h want 10_7e_00_00",
                     {d1_done, f1_rvalid}, d1_rdata, f1_rdata, mem1_wdata);
        end
        step(); // cycle 4
        checks++;
        if ({busy1, d1_done, d1_rdata} !== {2'b00, 8'h7E}) begin
            errors++;
            $display("FAIL lat1_idle got %b_%h want 00_7e", {busy1, d1_done}, d1_rdata);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        f_req = 1'b1; f_addr = 8'h50;
        step(); // cycle 1: ISSUE
        checks++;
        if (f_gnt !== 1'b1) begin
            errors++;
            $display("FAIL mid_gnt got %b want 1", f_gnt);
        end
        f_req = 1'b0;
        step(); // cycle 2: WAIT
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_en, busy, f_rvalid, f_rdata} !== {3'b000, 8'h00}) begin
            errors++;
            $display("FAIL mid_async got %b_%h want 000_00", {mem_en, busy, f_rvalid}, f_rdata);
        end
        step();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (f_rvalid || busy) seen = 1'b1;
        end
        checks++;
        if (seen || f_rdata !== 8'h00) begin
            errors++;
            $display("FAIL mid_dropped got pulse %b rdata %h want 0 00", seen, f_rdata);
        end
    endtask

    task automatic test_handoff();
        f_req = 1'b1; f_addr = 8'h50;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30;
        step(); // cycle 1
        checks++;
        if ({f_gnt, d_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL tie_after_reset got %b want 10", {f_gnt, d_gnt});
        end
        step(); // cycle 2
        step(); // cycle 3
        checks++;
        if ({f_gnt, d_gnt, mem_en} !== 3'b000) begin
            errors++;
            $display("FAIL req_ignored got %b want 000", {f_gnt, d_gnt, mem_en});
        end
        step(); // cycle 4: RESP
        checks++;
        if ({f_rvalid, d_done, f_rdata} !== {2'b10, 8'h3C}) begin
            errors++;
            $display("FAIL handoff_resp got %b_%h want 10_3c", {f_rvalid, d_done}, f_rdata);
        end
        f_req = 1'b0;
        step(); // cycle 5
        checks++;
        if ({f_gnt, d_gnt, mem_en, mem_addr} !== {3'b011, 8'h30}) begin
            errors++;
            $display("FAIL handoff_gnt got %b_%h want 011_30", {f_gnt, d_gnt, mem_en}, mem_addr);
        end
        d_req = 1'b0;
        step(); // cycle 6
        step(); // cycle 7
        step(); // cycle 8
        checks++;
        if ({d_done, f_rvalid, d_rdata, f_rdata} !== {2'b10, 8'hC3, 8'h3C}) begin
            errors++;
            $display("FAIL handoff_done got %b_%h_%h want 10_c3_3c", {d_done, f_rvalid}, d_rdata, f_rdata);
        end
        step(); // cycle 9
        checks++;
        if ({busy, d_done, f_gnt, d_gnt} !== 4'b0000) begin
            errors++;
            $display("FAIL handoff_idle got %b want 0000", {busy, d_done, f_gnt, d_gnt});
        end
    endtask

    initial begin
        step();
        test_reset();
        test_fetch_read();
        test_data_write();
        test_back_to_back();
        test_lat1_read();
        test_reset_mid();
        test_handoff();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
